// File: rtl/zircon_avalon_keyin_pkg.sv
// Shared constants for the key-input peripheral: register word addresses and
// the width of the per-key debounce counter.
package zircon_keyin_pkg;

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_EDGE  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_INFO  = 2'd3;

    localparam int CNT_W = 8;

endpackage

// File: rtl/zircon_avalon_keyin_if.sv
// Avalon-MM slave bus of the key-input peripheral: fixed read latency of one,
// no waitrequest.
interface zircon_avalon_keyin_if;

    logic [1:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

endinterface

// File: rtl/zircon_avalon_keyin_debounce.sv
// One key: two-flop synchroniser, tick-paced debounce counter and a one-cycle
// pulse when the debounced level goes to pressed (pin low).
module zircon_key_debounce
    import zircon_keyin_pkg::*;
#(
    parameter int DEB_TICKS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pin,
    output logic pressed,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    logic             sync_a;
    logic             sync_b;
    logic             deb;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            deb    <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
            press  <= 1'b0;
            // Any return of the synchronised level to deb abandons the count.
            if (sync_b == deb) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    deb   <= sync_b;
                    cnt   <= '0;
                    press <= ~sync_b;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign pressed = ~deb;

endmodule

// File: rtl/zircon_avalon_keyin.sv
// Avalon-MM key-input peripheral: debounced key state, sticky press flags with
// write-1-to-clear, per-key interrupt mask and a read-only info word.
module zircon_avalon_keyin
    import zircon_keyin_pkg::*;
#(
    parameter int KEY_NUM   = 4,
    parameter int TICK_DIV  = 50000,
    parameter int DEB_TICKS = 20
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset,
    zircon_avalon_keyin_if.slave  avs,
    output logic                  ins_irq,
    input  logic [KEY_NUM-1:0]    coe_key_in
);

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] press;
    logic [KEY_NUM-1:0] edge_flags;
    logic [KEY_NUM-1:0] irq_mask;
    logic [KEY_NUM-1:0] clr_bits;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        zircon_key_debounce #(
            .DEB_TICKS (DEB_TICKS)
        ) u_deb (
            .clk     (csi_clk),
            .reset   (rsi_reset),
            .tick    (tick),
            .pin     (coe_key_in[i]),
            .pressed (key_state[i]),
            .press   (press[i])
        );
    end

    assign clr_bits = (avs.write && avs.address == ADDR_EDGE)
                      ? avs.writedata[KEY_NUM-1:0] : '0;

    // Bits of writedata above KEY_NUM are intentionally dropped.
    assign unused_wdata = ^avs.writedata;

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            edge_flags <= '0;
            irq_mask   <= '0;
            ins_irq    <= 1'b0;
        end else begin
            // OR-ing press after the clear makes a same-cycle set win.
            edge_flags <= (edge_flags & ~clr_bits) | press;
            if (avs.write && avs.address == ADDR_MASK) begin
                irq_mask <= avs.writedata[KEY_NUM-1:0];
            end
            ins_irq <= |(edge_flags & irq_mask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_STATE: rd_mux = 32'(key_state);
            ADDR_EDGE:  rd_mux = 32'(edge_flags);
            ADDR_MASK:  rd_mux = 32'(irq_mask);
            ADDR_INFO:  rd_mux = {24'd0, 8'(KEY_NUM)};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            avs.readdata <= '0;
        end else if (avs.read) begin
            avs.readdata <= rd_mux;
        end
    end

endmodule
